// File: rtl/cam_axis_pkg.sv
// Shared types and constants for the CameraLink-to-AXI4-Stream framer.
package cam_axis_pkg;

  // Framer state: idle until a frame start, forwarding, or discarding after an overrun.
  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_ACTIVE     = 2'd1,
    ST_DROP       = 2'd2
  } state_t;

  // FIFO entry layout: pixel data in the LSBs, then the two flag bits above it.
  // Offsets of the flags are relative to the data width (TAPS*BPP).
  localparam int ENTRY_FLAG_BITS = 2;
  localparam int ENTRY_LAST_OFS  = 0;
  localparam int ENTRY_FIRST_OFS = 1;

  // Supported tap counts (Base through Full/80-bit configurations).
  localparam int TAPS_MIN = 1;
  localparam int TAPS_MAX = 10;

  // Width of one buffered beat including its flags.
  function automatic int entry_width(input int taps, input int bpp);
    return taps * bpp + ENTRY_FLAG_BITS;
  endfunction

  // True when the tap count lies within the supported range.
  function automatic bit taps_ok(input int taps);
    return (taps >= TAPS_MIN) && (taps <= TAPS_MAX);
  endfunction

endpackage

// File: rtl/cam_axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_data reads as zero while empty so the
// downstream bus idles at a known value. A push while full is accepted only
// when a pop happens in the same cycle (the freed slot is reused).
module cam_axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("cam_axis_sync_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cam_multitap_axis.sv
// CameraLink multi-tap to AXI4-Stream framer. Pixels qualified by
// FVAL/LVAL/DVAL pass through a one-beat lookahead register so the last beat
// of a line can be tagged before it enters the output FIFO. Frames that
// overrun the FIFO are dropped until the next frame start.
//
// Handshake: a beat transfers on m_axis when m_axis_tvalid and m_axis_tready
// are both high at the rising clock edge; once tvalid is raised the beat
// (tdata/tlast/tuser) is held unchanged until it transfers.
module cam_multitap_axis
  import cam_axis_pkg::*;
#(
  parameter int TAPS       = 3,
  parameter int BPP        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  input  logic                 s_cam_en,
  input  logic                 s_cam_fval,
  input  logic                 s_cam_lval,
  input  logic                 s_cam_dval,
  input  logic [TAPS*BPP-1:0]  s_cam_data,
  output logic [TAPS*BPP-1:0]  m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] frame_width,
  output logic [CNT_WIDTH-1:0] frame_height,
  output logic                 line_err,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output state_t               dbg_state
);

  localparam int DW = TAPS * BPP;
  localparam int EW = entry_width(TAPS, BPP);

  if (!taps_ok(TAPS)) begin : g_bad_taps
    $error("cam_multitap_axis: TAPS outside the supported range");
  end

  state_t               state_q, state_d;
  logic                 prev_fval_q, prev_lval_q;
  logic                 pend_valid_q, pend_valid_d;
  logic [DW-1:0]        pend_data_q, pend_data_d;
  logic                 pend_first_q, pend_first_d;
  logic                 first_q, first_d;
  logic [CNT_WIDTH-1:0] pix_q, pix_d;
  logic [CNT_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0] w0_q, w0_d;
  logic [CNT_WIDTH-1:0] fw_q, fw_d;
  logic [CNT_WIDTH-1:0] fh_q, fh_d;
  logic                 lerr_q, lerr_d;
  logic                 ovf_q;

  logic                 sof, eof, eol, qbeat;
  logic                 commit_req, overrun, push, pop;
  logic [EW-1:0]        push_entry;
  logic [EW-1:0]        head_entry;
  logic                 fifo_full, fifo_empty;

  // Edge events use the previous sampled fval/lval; samples with s_cam_en low are ignored.
  assign sof   = s_cam_en &&  s_cam_fval && !prev_fval_q;
  assign eof   = s_cam_en && !s_cam_fval &&  prev_fval_q;
  assign eol   = s_cam_en && !s_cam_lval &&  prev_lval_q;
  assign qbeat = s_cam_en &&  s_cam_fval &&  s_cam_lval && s_cam_dval;

  assign pop = m_axis_tvalid && m_axis_tready;

  // Next-state, lookahead commit and counter logic.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_first_d = pend_first_q;
    first_d      = first_q;
    pix_d        = pix_q;
    line_d       = line_q;
    w0_d         = w0_q;
    fw_d         = fw_q;
    fh_d         = fh_q;
    lerr_d       = 1'b0;
    commit_req   = 1'b0;
    overrun      = 1'b0;
    push         = 1'b0;
    push_entry   = '0;

    // The frame-start sample itself belongs to the new frame, whatever the state.
    if ((state_q == ST_ACTIVE) || sof) begin
      if (sof) begin
        state_d = ST_ACTIVE;
        first_d = 1'b1;
        pix_d   = '0;
        line_d  = '0;
      end

      commit_req = pend_valid_q && (qbeat || eol || eof);

      if (commit_req && fifo_full && !pop) begin
        // Refused commit: lose the pending beat and the rest of this frame.
        overrun      = 1'b1;
        state_d      = ST_DROP;
        pend_valid_d = 1'b0;
      end else begin
        if (commit_req) begin
          push                           = 1'b1;
          push_entry[DW-1:0]             = pend_data_q;
          push_entry[DW+ENTRY_LAST_OFS]  = !qbeat;
          push_entry[DW+ENTRY_FIRST_OFS] = pend_first_q;
          pend_valid_d                   = 1'b0;
        end
        if (qbeat) begin
          pend_valid_d = 1'b1;
          pend_data_d  = s_cam_data;
          pend_first_d = first_d;
          first_d      = 1'b0;
          pix_d        = (&pix_d) ? pix_d : pix_d + 1'b1;
        end
        if (eol) begin
          // Lines with no qualified beats are ignored entirely.
          if (pix_d != '0) begin
            fw_d = pix_d;
            if (line_d == '0) begin
              w0_d = pix_d;
            end else if (pix_d != w0_q) begin
              lerr_d = 1'b1;
            end
            line_d = (&line_d) ? line_d : line_d + 1'b1;
          end
          pix_d = '0;
        end
        if (eof) begin
          fh_d   = line_d;
          pix_d  = '0;
          line_d = '0;
        end
      end
    end
  end

  // State, lookahead, counters and status registers.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_WAIT_FRAME;
      // Starting high means a frame already in progress at reset release is
      // not mistaken for a frame start.
      prev_fval_q  <= 1'b1;
      prev_lval_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_first_q <= 1'b0;
      first_q      <= 1'b0;
      pix_q        <= '0;
      line_q       <= '0;
      w0_q         <= '0;
      fw_q         <= '0;
      fh_q         <= '0;
      lerr_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (s_cam_en) begin
        prev_fval_q <= s_cam_fval;
        prev_lval_q <= s_cam_lval;
      end
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_first_q <= pend_first_d;
      first_q      <= first_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      w0_q         <= w0_d;
      fw_q         <= fw_d;
      fh_q         <= fh_d;
      lerr_q       <= lerr_d;
      if (overrun) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  cam_axis_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (axis_clk),
    .rst_n   (aresetn),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = head_entry[DW-1:0];
  assign m_axis_tlast  = head_entry[DW+ENTRY_LAST_OFS];
  assign m_axis_tuser  = head_entry[DW+ENTRY_FIRST_OFS];
  assign frame_width   = fw_q;
  assign frame_height  = fh_q;
  assign line_err      = lerr_q;
  assign overflow      = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cam_multitap_axis.sv
// Bench for cam_multitap_axis. Two instances share one camera stimulus:
// u_a (3 taps x 8 bits, 4-deep FIFO) and u_b (10 taps x 12 bits, 16-deep).
// Expected beats and frame statistics come from a frame-level model: each
// frame is described by its line widths, and the model derives the beat
// list, flags, widths, height and line-error count from that description.
module tb_cam_multitap_axis;
  import cam_axis_pkg::*;

  localparam int DWA = 24;
  localparam int DWB = 120;

  // Clock and reset
  logic axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  logic           aresetn;
  logic           s_cam_en, s_cam_fval, s_cam_lval, s_cam_dval, ovf_clr;
  logic [DWB-1:0] s_cam_data;
  logic           tready_a, tready_b;

  logic [DWA-1:0] tdata_a;
  logic           tvalid_a, tlast_a, tuser_a, lerr_a, ovf_a;
  logic [15:0]    fw_a, fh_a;
  state_t         st_a;
  logic [DWB-1:0] tdata_b;
  logic           tvalid_b, tlast_b, tuser_b, lerr_b, ovf_b;
  logic [15:0]    fw_b, fh_b;
  state_t         st_b;

  cam_multitap_axis #(.TAPS(3), .BPP(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u_a (
    .axis_clk(axis_clk), .aresetn(aresetn), .s_cam_en(s_cam_en),
    .s_cam_fval(s_cam_fval), .s_cam_lval(s_cam_lval), .s_cam_dval(s_cam_dval),
    .s_cam_data(s_cam_data[DWA-1:0]), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
    .m_axis_tready(tready_a), .m_axis_tlast(tlast_a), .m_axis_tuser(tuser_a),
    .frame_width(fw_a), .frame_height(fh_a), .line_err(lerr_a), .overflow(ovf_a),
    .ovf_clr(ovf_clr), .dbg_state(st_a));

  cam_multitap_axis #(.TAPS(10), .BPP(12), .FIFO_DEPTH(16), .CNT_WIDTH(16)) u_b (
    .axis_clk(axis_clk), .aresetn(aresetn), .s_cam_en(s_cam_en),
    .s_cam_fval(s_cam_fval), .s_cam_lval(s_cam_lval), .s_cam_dval(s_cam_dval),
    .s_cam_data(s_cam_data), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(tready_b), .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b),
    .frame_width(fw_b), .frame_height(fh_b), .line_err(lerr_b), .overflow(ovf_b),
    .ovf_clr(ovf_clr), .dbg_state(st_b));

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [DWA+1:0] exp_a_q[$];
  logic [DWB+1:0] exp_b_q[$];
  int lerr_cnt_a = 0, lerr_cnt_b = 0;
  int lerr_base_a, lerr_base_b;
  int exp_lerr_a, exp_lerr_b;
  int exp_fw_a = 0, exp_fh_a = 0, exp_fw_b = 0, exp_fh_b = 0;

  // Stimulus controls
  bit expect_out   = 1'b1;
  int a_keep       = -1;
  int clr_at_beat  = 0;
  bit rand_ready_b = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: compare transferred beats, check stall stability, count line_err pulses.
  logic [DWB+1:0] prev_b;
  bit             stall_b = 1'b0;
  always @(negedge axis_clk) begin
    if (!aresetn) begin
      stall_b <= 1'b0;
    end else begin
      if (tvalid_a && tready_a) begin
        check("a_beat_expected", exp_a_q.size() != 0, 1);
        if (exp_a_q.size() != 0) check("a_beat", {tuser_a, tlast_a, tdata_a}, exp_a_q.pop_front());
      end
      if (tvalid_b && tready_b) begin
        check("b_beat_expected", exp_b_q.size() != 0, 1);
        if (exp_b_q.size() != 0) check("b_beat", {tuser_b, tlast_b, tdata_b}, exp_b_q.pop_front());
      end
      if (stall_b && tvalid_b) check("b_stall_stable", {tuser_b, tlast_b, tdata_b}, prev_b);
      stall_b <= tvalid_b && !tready_b;
      prev_b  <= {tuser_b, tlast_b, tdata_b};
      if (lerr_a) lerr_cnt_a <= lerr_cnt_a + 1;
      if (lerr_b) lerr_cnt_b <= lerr_cnt_b + 1;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge axis_clk);
    #1;
    if (rand_ready_b) tready_b = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat_noexp();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    s_cam_en = 1'b1; s_cam_lval = 1'b1; s_cam_dval = 1'b1; s_cam_data = t[DWB-1:0];
    tick();
  endtask

  // Drives one frame of nl lines with widths w[]; mode 0 drops LVAL before
  // FVAL, mode 1 drops both together, mode 2 drops FVAL while LVAL lingers
  // (that last line then never sees an in-frame line end).
  task automatic drive_frame(input int nl, input int w[8], input bit gaps, input int mode);
    logic [127:0] t;
    int k, counted, errs;
    k = 0;
    lerr_base_a = lerr_cnt_a;
    lerr_base_b = lerr_cnt_b;
    s_cam_en = 1'b1; s_cam_fval = 1'b1; s_cam_lval = 1'b0; s_cam_dval = 1'b0;
    tick(); tick();
    for (int i = 0; i < nl; i++) begin
      for (int j = 0; j < w[i]; j++) begin
        if (gaps) begin
          while ($urandom_range(0, 3) == 0) begin
            s_cam_en = 1'($urandom_range(0, 1)); s_cam_lval = 1'b1; s_cam_dval = !s_cam_en;
            tick();
          end
        end
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_cam_en = 1'b1; s_cam_lval = 1'b1; s_cam_dval = 1'b1; s_cam_data = t[DWB-1:0];
        k++;
        ovf_clr = (k == clr_at_beat);
        if (expect_out) begin
          if (a_keep < 0 || k <= a_keep)
            exp_a_q.push_back({1'(i == 0 && j == 0), 1'(j == w[i] - 1 && a_keep < 0), t[DWA-1:0]});
          exp_b_q.push_back({1'(i == 0 && j == 0), 1'(j == w[i] - 1), t[DWB-1:0]});
        end
        tick();
        ovf_clr = 1'b0;
      end
      s_cam_dval = 1'b0;
      if (i == nl - 1 && mode == 1) begin
        s_cam_lval = 1'b0; s_cam_fval = 1'b0; tick();
      end else if (i == nl - 1 && mode == 2) begin
        s_cam_fval = 1'b0; tick(); s_cam_lval = 1'b0; tick();
      end else begin
        s_cam_lval = 1'b0; tick(); tick();
      end
    end
    s_cam_fval = 1'b0; s_cam_lval = 1'b0; s_cam_dval = 1'b0;
    tick(); tick(); tick();
    // Frame statistics from the line list.
    counted = (mode == 2) ? nl - 1 : nl;
    errs = 0;
    for (int i = 1; i < counted; i++) if (w[i] != w[0]) errs++;
    if (expect_out) begin
      exp_lerr_b = errs; exp_fh_b = counted;
      if (counted > 0) exp_fw_b = w[counted-1];
      if (a_keep < 0) begin
        exp_lerr_a = errs; exp_fh_a = counted;
        if (counted > 0) exp_fw_a = w[counted-1];
      end else begin
        exp_lerr_a = 0;
      end
    end
  endtask

  // Drain both outputs (bounded) then compare frame statistics.
  task automatic check_frame(input string tag);
    for (int n = 0; n < 1000 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); n++) tick();
    check({tag, "_a_drained"}, exp_a_q.size(), 0);
    check({tag, "_b_drained"}, exp_b_q.size(), 0);
    tick();
    if (tready_a) check({tag, "_a_idle"}, tvalid_a, 0);
    check({tag, "_a_width"}, fw_a, exp_fw_a);
    check({tag, "_a_height"}, fh_a, exp_fh_a);
    check({tag, "_a_lerr"}, lerr_cnt_a - lerr_base_a, exp_lerr_a);
    check({tag, "_b_width"}, fw_b, exp_fw_b);
    check({tag, "_b_height"}, fh_b, exp_fh_b);
    check({tag, "_b_lerr"}, lerr_cnt_b - lerr_base_b, exp_lerr_b);
    check({tag, "_b_overflow"}, ovf_b, 0);
  endtask

  // Hard time limit
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int w[8];
    aresetn = 1'b0; s_cam_en = 1'b0; s_cam_fval = 1'b0; s_cam_lval = 1'b0;
    s_cam_dval = 1'b0; s_cam_data = '0; ovf_clr = 1'b0; tready_a = 1'b1; tready_b = 1'b1;
    repeat (3) tick();
    check("rst_a_tvalid", tvalid_a, 0);
    check("rst_b_tdata", tdata_b, 0);
    check("rst_b_tlast", tlast_b, 0);
    check("rst_a_tuser", tuser_a, 0);
    check("rst_a_width", fw_a, 0);
    check("rst_b_height", fh_b, 0);
    check("rst_a_lerr", lerr_a, 0);
    check("rst_a_overflow", ovf_a, 0);
    check("rst_a_state", st_a, ST_WAIT_FRAME);
    aresetn = 1'b1; s_cam_en = 1'b1;
    tick(); tick();

    // 4 lines x 5 beats, no gaps, always ready.
    w = '{5, 5, 5, 5, 0, 0, 0, 0};
    drive_frame(4, w, 1'b0, 0);
    check_frame("basic");

    // 10-beat line into a stalled 4-deep FIFO: b1..b4 fill it, b5 sits in the
    // lookahead, and the 6th beat's commit of b5 is refused. ovf_clr is raised
    // on exactly that sample, so the set must win.
    tready_a = 1'b0; a_keep = 4; clr_at_beat = 6;
    w = '{10, 0, 0, 0, 0, 0, 0, 0};
    drive_frame(1, w, 1'b0, 0);
    check("ovf_set_beats_clr", ovf_a, 1);
    check("ovf_state_drop", st_a, ST_DROP);
    check("ovf_a_holding", tvalid_a, 1);
    tready_a = 1'b1; a_keep = -1; clr_at_beat = 0;
    check_frame("ovf");
    check("ovf_sticky", ovf_a, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf_a, 0);

    // Width mismatch on the third line only.
    w = '{8, 8, 6, 8, 0, 0, 0, 0};
    drive_frame(4, w, 1'b1, 0);
    check_frame("lerr");

    // Reset lands mid-frame with beats buffered; released while FVAL is still high.
    expect_out = 1'b0; tready_a = 1'b0; tready_b = 1'b0;
    s_cam_en = 1'b1; s_cam_fval = 1'b1; s_cam_lval = 1'b0; s_cam_dval = 1'b0;
    tick(); tick();
    repeat (3) drive_beat_noexp();
    check("midrst_a_valid_before", tvalid_a, 1);
    aresetn = 1'b0;
    #1;
    check("midrst_a_valid_async", tvalid_a, 0);
    check("midrst_b_tdata_async", tdata_b, 0);
    tick();
    repeat (2) drive_beat_noexp();
    aresetn = 1'b1;
    repeat (3) drive_beat_noexp();
    s_cam_lval = 1'b0; s_cam_dval = 1'b0; tick(); tick();
    repeat (4) drive_beat_noexp();
    s_cam_lval = 1'b0; s_cam_dval = 1'b0; tick();
    check("midrst_a_state", st_a, ST_WAIT_FRAME);
    s_cam_fval = 1'b0; tick();
    tready_a = 1'b1; tready_b = 1'b1;
    repeat (4) tick();
    check("midrst_a_no_output", tvalid_a, 0);
    check("midrst_b_no_output", tvalid_b, 0);
    check("midrst_a_width_reset", fw_a, 0);
    expect_out = 1'b1;
    exp_fw_a = 0; exp_fh_a = 0; exp_fw_b = 0; exp_fh_b = 0;
    w = '{4, 4, 4, 0, 0, 0, 0, 0};
    drive_frame(3, w, 1'b0, 0);
    check_frame("postrst");

    // Random frames, 50% ready on the wide instance, random gaps and frame endings.
    rand_ready_b = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int nl;
      nl = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) w[i] = $urandom_range(1, 12);
      drive_frame(nl, w, 1'b1, $urandom_range(0, 2));
      check_frame("rand");
    end
    rand_ready_b = 1'b0; tready_b = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
